// File: rtl/inst_axi_bridge.sv
// Instruction-fetch SRAM-like to AXI read bridge, one outstanding single-beat read.
// Define INST_BRIDGE_FLUSH_EN to compile in flush handling (discard of an in-flight fetch).
module inst_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic [31:0] inst_sram_addr_ok_addr,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        flush,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] rdata_q;
    logic        discard;
    logic        flush_hit;
    logic        suppress;

    // Response tagging and flush (when compiled out) carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rresp, rlast, flush};

`ifdef INST_BRIDGE_FLUSH_EN
    // A flush only matters once the fetch has left IDLE.
    assign flush_hit = flush && (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            discard <= 1'b0;
        end else if (state_next == IDLE) begin
            discard <= 1'b0;
        end else if (flush_hit) begin
            discard <= 1'b1;
        end
    end
`else
    assign flush_hit = 1'b0;
    assign discard   = 1'b0;
`endif

    // Same-cycle flush suppresses the handshake pulse as well as a registered one.
    assign suppress = discard || flush_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            rdata_q <= 32'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (inst_sram_en) begin
                        addr_q <= inst_sram_addr;
                        size_q <= inst_sram_size;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rdata_q <= rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next        = state;
        arvalid           = 1'b0;
        rready            = 1'b0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        case (state)
            IDLE: begin
                if (inst_sram_en) begin
                    state_next = AR;
                end
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    inst_sram_addr_ok = !suppress;
                    state_next        = R;
                end
            end
            R: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                inst_sram_data_ok = !suppress;
                state_next        = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign araddr                 = addr_q;
    assign arsize                 = {1'b0, size_q};
    assign arid                   = AXI_ID;
    assign arlen                  = 8'd0;
    assign arburst                = 2'b01;
    assign arlock                 = 2'b00;
    assign arcache                = 4'd0;
    assign arprot                 = 3'd0;
    assign inst_sram_addr_ok_addr = addr_q;
    assign inst_sram_rdata        = rdata_q;

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Self-checking bench for inst_axi_bridge: directed scenarios plus randomized fetches
// checked against a transaction-level model of the fetch protocol.
module tb_inst_axi_bridge;

`ifdef INST_BRIDGE_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        inst_sram_en;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic [31:0] inst_sram_addr_ok_addr;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        flush;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_word = 32'd0;

    inst_axi_bridge #(.AXI_ID(4'd0)) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .inst_sram_en           (inst_sram_en),
        .inst_sram_size         (inst_sram_size),
        .inst_sram_addr         (inst_sram_addr),
        .inst_sram_addr_ok      (inst_sram_addr_ok),
        .inst_sram_addr_ok_addr (inst_sram_addr_ok_addr),
        .inst_sram_data_ok      (inst_sram_data_ok),
        .inst_sram_rdata        (inst_sram_rdata),
        .flush                  (flush),
        .arid                   (arid),
        .araddr                 (araddr),
        .arlen                  (arlen),
        .arsize                 (arsize),
        .arburst                (arburst),
        .arlock                 (arlock),
        .arcache                (arcache),
        .arprot                 (arprot),
        .arvalid                (arvalid),
        .arready                (arready),
        .rid                    (rid),
        .rdata                  (rdata),
        .rresp                  (rresp),
        .rlast                  (rlast),
        .rvalid                 (rvalid),
        .rready                 (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Memory contents seen by the bridge: a fixed scramble of the address.
    function automatic logic [31:0] model_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a3c_96e1;
    endfunction

    // One complete fetch. fmode: 0 none, 1 flush in first AR cycle, 2 flush in first
    // R cycle, 3 flush in RESP, 4 flush in the IDLE request cycle (must be harmless).
    task automatic fetch(input logic [31:0] a, input logic [1:0] sz, input int ard,
                         input int rd, input logic [31:0] w, input int fmode, input bit noise);
        logic exp_aok;
        logic exp_dok;
        exp_aok = !(FLUSH_EN && fmode == 1);
        exp_dok = !(FLUSH_EN && (fmode == 1 || fmode == 2 || fmode == 3));

        @(negedge clk);
        inst_sram_en = 1'b1; inst_sram_addr = a; inst_sram_size = sz;
        flush = (fmode == 4); arready = 1'b0; rvalid = 1'b0;
        #1;
        chk("idle_arvalid", arvalid, 0);
        chk("idle_data_ok", inst_sram_data_ok, 0);
        chk("idle_rdata_hold", inst_sram_rdata, last_word);

        for (int i = 0; i <= ard; i++) begin
            @(negedge clk);
            inst_sram_en   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            inst_sram_addr = a + 32'd4;
            inst_sram_size = 2'($urandom_range(0, 3));
            flush          = (fmode == 1 && i == 0);
            arready        = (i == ard);
            #1;
            chk("ar_arvalid", arvalid, 1);
            chk("ar_araddr", araddr, a);
            chk("ar_addr_ok_addr", inst_sram_addr_ok_addr, a);
            chk("ar_arsize", arsize, {1'b0, sz});
            chk("ar_rready", rready, 0);
            chk("ar_addr_ok", inst_sram_addr_ok, (i == ard) ? exp_aok : 1'b0);
        end
        chk("const_arid", arid, 0);
        chk("const_arlen", arlen, 0);
        chk("const_arburst", arburst, 1);
        chk("const_misc", {arlock, arcache, arprot}, 0);

        for (int i = 0; i <= rd; i++) begin
            @(negedge clk);
            inst_sram_en = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            arready      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            rvalid       = (i == rd);
            rdata        = (i == rd) ? w : $urandom;
            rid          = 4'($urandom_range(0, 15));
            rresp        = 2'($urandom_range(0, 3));
            rlast        = 1'($urandom_range(0, 1));
            flush        = (fmode == 2 && i == 0);
            #1;
            chk("r_rready", rready, 1);
            chk("r_arvalid", arvalid, 0);
            chk("r_data_ok", inst_sram_data_ok, 0);
            chk("r_addr_ok", inst_sram_addr_ok, 0);
        end

        @(negedge clk);
        rvalid = 1'b0; arready = 1'b0; rdata = $urandom;
        flush = (fmode == 3);
        inst_sram_en = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        chk("resp_data_ok", inst_sram_data_ok, exp_dok);
        chk("resp_rdata", inst_sram_rdata, w);
        chk("resp_arvalid", arvalid, 0);
        chk("resp_rready", rready, 0);
        last_word = w;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        inst_sram_en = 1'b0; flush = 1'b0; arready = 1'b0; rvalid = 1'b0;
        #1;
        chk("quiet_arvalid", arvalid, 0);
        chk("quiet_data_ok", inst_sram_data_ok, 0);
        chk("quiet_rdata_hold", inst_sram_rdata, last_word);
    endtask

    initial begin
        logic [31:0] a;
        resetn = 1'b0; inst_sram_en = 1'b1; inst_sram_size = 2'd2;
        inst_sram_addr = 32'hdead_beef; flush = 1'b0; arready = 1'b1;
        rid = 4'd0; rdata = 32'hffff_ffff; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b1;

        // Reset state, with stimulus active to show it is ignored.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_addr_ok", inst_sram_addr_ok, 0);
        chk("rst_data_ok", inst_sram_data_ok, 0);
        chk("rst_addr_ok_addr", inst_sram_addr_ok_addr, 0);
        chk("rst_rdata", inst_sram_rdata, 0);
        @(negedge clk);
        resetn = 1'b1; inst_sram_en = 1'b0; arready = 1'b0; rvalid = 1'b0;

        // Boot fetch at minimum AR latency.
        fetch(32'hbfc0_0000, 2'd2, 0, 2, 32'h3c1a_0000, 0, 1'b0);
        // Stalled AR with the IF address moving on.
        fetch(32'hbfc0_0000, 2'd2, 5, 0, 32'h0000_0001, 0, 1'b0);
        // Requests during AR/R/RESP ignored; back-to-back from IDLE.
        fetch(32'hbfc0_0008, 2'd2, 1, 3, model_word(32'hbfc0_0008), 0, 1'b1);
        fetch(32'hbfc0_000c, 2'd1, 0, 0, model_word(32'hbfc0_000c), 0, 1'b1);
        // Flush during R, then a normal fetch.
        fetch(32'hbfc0_0010, 2'd2, 0, 1, 32'h1234_5678, 2, 1'b0);
        fetch(32'hbfc0_0380, 2'd2, 0, 0, model_word(32'hbfc0_0380), 0, 1'b0);
        // Flush in AR (including same cycle as arready), in RESP, and in IDLE.
        fetch(32'h8000_0100, 2'd2, 2, 1, model_word(32'h8000_0100), 1, 1'b0);
        fetch(32'h8000_0104, 2'd2, 0, 0, model_word(32'h8000_0104), 1, 1'b0);
        fetch(32'h8000_0108, 2'd2, 0, 2, model_word(32'h8000_0108), 3, 1'b0);
        fetch(32'h8000_010c, 2'd2, 1, 0, model_word(32'h8000_010c), 4, 1'b0);
        idle_cycle();

        // Reset while waiting for read data; a late beat must not complete anything.
        @(negedge clk);
        inst_sram_en = 1'b1; inst_sram_addr = 32'hbfc0_0040; inst_sram_size = 2'd2;
        @(negedge clk);
        inst_sram_en = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        #1;
        chk("pre_rst_rready", rready, 1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midrst_rready", rready, 0);
        chk("midrst_arvalid", arvalid, 0);
        chk("midrst_addr_ok_addr", inst_sram_addr_ok_addr, 0);
        chk("midrst_rdata", inst_sram_rdata, 0);
        @(negedge clk);
        resetn = 1'b1; rvalid = 1'b1; rdata = 32'h0bad_0bad;
        #1;
        chk("post_rst_rready", rready, 0);
        last_word = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rvalid = 1'b0;
            #1;
            chk("post_rst_data_ok", inst_sram_data_ok, 0);
            chk("post_rst_rdata", inst_sram_rdata, 0);
        end

        // Randomized fetches.
        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            a[1:0] = 2'b00;
            fetch(a, 2'($urandom_range(0, 3)), $urandom_range(0, 4), $urandom_range(0, 4),
                  model_word(a), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_axi_bridge.md
INST_AXI_BRIDGE -- requirements
Module: inst_axi_bridge

Interface
REQ-001 SHALL have parameter: AXI_ID, 4'd0, constant value driven on arid.
REQ-002 SHALL have port: clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port: resetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: inst_sram_en  in  1  fetch request from IF stage.
REQ-005 SHALL have port: inst_sram_size  in  2  transfer size, copied to arsize.
REQ-006 SHALL have port: inst_sram_addr  in  32  physical fetch address.
REQ-007 SHALL have port: inst_sram_addr_ok  out  1  address-accepted pulse.
REQ-008 SHALL have port: inst_sram_addr_ok_addr  out  32  address the current addr_ok belongs to.
REQ-009 SHALL have port: inst_sram_data_ok  out  1  read-data-valid pulse.
REQ-010 SHALL have port: inst_sram_rdata  out  32  fetched instruction word.
REQ-011 SHALL have port: flush  in  1  cancel in-flight fetch (exception/ERET redirect).
REQ-012 SHALL have ports: arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1 (out); arready 1 (in).
REQ-013 SHALL have ports: rid 4, rdata 32, rresp 2, rlast 1, rvalid 1 (in); rready 1 (out).

Function
REQ-014 SHALL implement FSM states IDLE, AR, R, RESP; one transaction outstanding at most.
REQ-015 IDLE: inst_sram_en=1 -> latch inst_sram_addr/size into addr_q/size_q, go to AR next cycle.
REQ-016 AR: arvalid=1, araddr=addr_q, arsize={1'b0,size_q}; addr_q/araddr SHALL remain stable until arready.
REQ-017 AR with arready=1 -> inst_sram_addr_ok=1 that same cycle, go to R.
REQ-018 inst_sram_addr_ok_addr SHALL always equal addr_q, so IF discards addr_ok when its current address differs.
REQ-019 R: rready=1; rvalid=1 -> capture rdata into rdata_q, go to RESP.
REQ-020 RESP: inst_sram_data_ok=1 for exactly one cycle, inst_sram_rdata=rdata_q, then IDLE.
REQ-021 Minimum latency: en at cycle 0, arvalid cycle 1, addr_ok cycle 1 if arready, data_ok one cycle after rvalid.
REQ-022 Requests SHALL be sampled only in IDLE; inst_sram_en in AR/R/RESP ignored.
REQ-023 Constants: arid=AXI_ID, arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0.
REQ-024 rid, rresp, rlast SHALL be ignored; rdata passed through regardless of rresp.
REQ-025 inst_sram_rdata SHALL hold last captured word between data_ok pulses.

Reset
REQ-026 resetn=0 SHALL asynchronously force state=IDLE, addr_q=0, size_q=0, rdata_q=0, discard=0.
REQ-027 During reset: arvalid=0, rready=0, addr_ok=0, data_ok=0, addr_ok_addr=0, rdata=0.
REQ-028 Reset mid-transaction SHALL abandon the transaction; no data_ok follows reset release.

Configuration
REQ-029 Macro INST_BRIDGE_FLUSH_EN SHALL compile in flush handling with discard flag.
REQ-030 With macro: flush in AR SHALL set discard, suppress addr_ok, keep arvalid until arready (no AXI withdrawal).
REQ-031 With macro: flush in R or RESP SHALL set discard; R beat still consumed; data_ok suppressed for that transaction.
REQ-032 With macro: discard cleared on return to IDLE; flush in IDLE no effect; flush and rvalid same cycle -> beat discarded.
REQ-033 Without macro: flush port present but ignored; discard constant 0.

Verification
REQ-034 Reset, en=1 addr=0xbfc00000, arready=1 at once, rvalid 2 cycles later rdata=0x3c1a0000 -> addr_ok cycle 1 with addr_ok_addr=0xbfc00000; data_ok one cycle after rvalid with rdata=0x3c1a0000.
REQ-035 arready held low 5 cycles while inst_sram_addr changes to 0xbfc00004 -> araddr stays 0xbfc00000, addr_ok_addr=0xbfc00000, single AR handshake.
REQ-036 en=1 during R state -> no second arvalid until after RESP; next request accepted only in IDLE.
REQ-037 Macro on: flush in R, rvalid next cycle rdata=0x12345678 -> rready handshake occurs, no data_ok; following fetch 0xbfc00380 returns data_ok normally.
REQ-038 resetn low while in R for 1 cycle -> outputs zero immediately; late rvalid after release produces no data_ok.
